// File: rtl/chess_pkg.sv
// +--------------------------------------------------------------------------+
// | chess_pkg : shared encodings and square helper for move entry control    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package chess_pkg;

  localparam int SQ_W      = 6;
  localparam int COORD_MAX = 7;

  typedef enum logic [1:0] {
    ST_FROM = 2'b00,
    ST_TO   = 2'b01,
    ST_REQ  = 2'b10
  } state_e;

  function automatic logic [SQ_W-1:0] make_sq(input logic [2:0] rank, input logic [2:0] file);
    return {rank, file};
  endfunction

endpackage

`default_nettype wire

// File: rtl/sec_tick_gen.sv
// +--------------------------------------------------------------------------+
// | sec_tick_gen : free-running prescaler, one-cycle tick every CLK_HZ clocks |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module sec_tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt_q;

  assign tick = en && (cnt_q == C_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == C_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/move_entry_ctrl.sv
// +--------------------------------------------------------------------------+
// | move_entry_ctrl : FROM/TO digit entry, move req/ack handshake, turn owner |
// | Optional per-turn countdown built when TURN_TIMER_EN is defined.         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module move_entry_ctrl
  import chess_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int TURN_SECONDS = 60
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      digit1,
  input  logic [3:0]      digit2,
  input  logic            verify,
  input  logic            cancel,
  input  logic            move_ack,
  input  logic            move_nack,
  output logic            move_req,
  output logic [SQ_W-1:0] from_sq,
  output logic [SQ_W-1:0] to_sq,
  output logic            player,
  output logic [1:0]      state_code,
  output logic            err,
  output logic            turn_timeout,
  output logic [7:0]      time_left
);

  state_e          state_q;
  logic            move_req_q;
  logic            player_q;
  logic            err_q;
  logic [SQ_W-1:0] from_q;
  logic [SQ_W-1:0] to_q;

  logic            w_legal;
  logic [SQ_W-1:0] w_sq;
  logic            w_expire;

  assign w_legal = (digit1 <= 4'(COORD_MAX)) && (digit2 <= 4'(COORD_MAX));
  assign w_sq    = make_sq(digit2[2:0], digit1[2:0]);

`ifdef TURN_TIMER_EN
  localparam logic [7:0] C_TURN = 8'(TURN_SECONDS);

  logic       w_tick;
  logic       w_run;
  logic       w_pres_clr;
  logic [7:0] time_q;
  logic       timeout_q;

  assign w_run      = (state_q != ST_REQ);
  assign w_expire   = w_tick && w_run && (time_q == 8'd1);
  assign w_pres_clr = reset || w_expire || ((state_q == ST_REQ) && move_ack);

  sec_tick_gen #(
    .CLK_HZ(CLK_HZ)
  ) u_tick (
    .clk  (clk),
    .reset(w_pres_clr),
    .en   (w_run),
    .tick (w_tick)
  );

  // Expiry shows 0 for the timeout cycle, then reloads for the new player.
  always_ff @(posedge clk) begin
    timeout_q <= 1'b0;
    if (reset) begin
      time_q <= C_TURN;
    end else if ((state_q == ST_REQ) && move_ack) begin
      time_q <= C_TURN;
    end else if (timeout_q) begin
      time_q <= C_TURN;
    end else if (w_expire) begin
      time_q    <= 8'd0;
      timeout_q <= 1'b1;
    end else if (w_tick && w_run && (time_q != 8'd0)) begin
      time_q <= time_q - 8'd1;
    end
  end

  assign turn_timeout = timeout_q;
  assign time_left    = time_q;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{32'(CLK_HZ), 32'(TURN_SECONDS)};
  assign w_expire     = 1'b0;
  assign turn_timeout = 1'b0;
  assign time_left    = 8'd0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_FROM;
      move_req_q <= 1'b0;
      player_q   <= 1'b0;
      err_q      <= 1'b0;
      from_q     <= '0;
      to_q       <= '0;
    end else begin
      err_q <= 1'b0;
      if (w_expire) begin
        player_q <= ~player_q;
        state_q  <= ST_FROM;
      end else begin
        case (state_q)
          ST_FROM: begin
            if (verify) begin
              if (w_legal) begin
                from_q  <= w_sq;
                state_q <= ST_TO;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          ST_TO: begin
            if (cancel) begin
              state_q <= ST_FROM;
            end else if (verify) begin
              if (w_legal && (w_sq != from_q)) begin
                to_q       <= w_sq;
                move_req_q <= 1'b1;
                state_q    <= ST_REQ;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          ST_REQ: begin
            if (move_ack) begin
              move_req_q <= 1'b0;
              player_q   <= ~player_q;
              state_q    <= ST_FROM;
            end else if (move_nack) begin
              move_req_q <= 1'b0;
              err_q      <= 1'b1;
              state_q    <= ST_FROM;
            end
          end
          default: state_q <= ST_FROM;
        endcase
      end
    end
  end

  assign move_req   = move_req_q;
  assign from_sq    = from_q;
  assign to_sq      = to_q;
  assign player     = player_q;
  assign state_code = state_q;
  assign err        = err_q;

endmodule

`default_nettype wire
